// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: time-setting controller for the hh:mm digit counter chain.
//   Two debounced buttons step through H10/H1/M10/M1 editing; a final mode press
//   issues a LOAD_CYCLES-long load_o strobe that presets the counters with ival_*_o.
// Ports:
//   clk_i, rstn_i           : clock, async active-low reset
//   btn_mode_i, btn_inc_i   : raw asynchronous push buttons (active high)
//   ival_h10/h1/m10/m1_o    : edited digit values (held between loads)
//   load_o                  : load strobe to the counters' synchronous reset
//   setting_o, sel_o        : in-edit flag and one-hot selected digit
//   blink_o                 : blink enable for the selected digit
module watch_set_ctrl #(
  parameter int DEB_CYCLES  = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int BLINK_DIV   = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  output logic [3:0] ival_h10_o,
  output logic [3:0] ival_h1_o,
  output logic [3:0] ival_m10_o,
  output logic [3:0] ival_m1_o,
  output logic       load_o,
  output logic       setting_o,
  output logic [3:0] sel_o,
  output logic       blink_o
);

  localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int LOAD_W  = $clog2(LOAD_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  typedef enum logic [2:0] {
    ST_RUN, ST_SET_H10, ST_SET_H1, ST_SET_M10, ST_SET_M1, ST_LOAD
  } state_t;

  // ------------------------------------------------------------------
  // Button conditioning: index 0 = mode, index 1 = increment.
  // ------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] press_evt;
  assign btn_raw = {btn_inc_i, btn_mode_i};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic             sync1_q, sync2_q;
    logic             lvl_q, lvl_prev_q;
    logic [DEB_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        lvl_q      <= 1'b0;
        lvl_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= btn_raw[g];
        sync2_q    <= sync1_q;
        lvl_prev_q <= lvl_q;
        // The counter tracks the run of samples disagreeing with the accepted
        // level; the DEB_CYCLES-th disagreeing sample flips the level.
        if (sync2_q != lvl_q) begin
          if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
            lvl_q <= sync2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    // Only the rising edge of the accepted level is an event.
    assign press_evt[g] = lvl_q & ~lvl_prev_q;
  end

  logic mode_evt, inc_evt;
  assign mode_evt = press_evt[0];
  assign inc_evt  = press_evt[1];

  // ------------------------------------------------------------------
  // State machine and digit registers
  // ------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
  logic [3:0]          h10_q, h1_q, m10_q, m1_q;
  logic [3:0]          h10_d, h1_d, m10_d, m1_d;

  function automatic logic is_set(state_t s);
    return (s == ST_SET_H10) || (s == ST_SET_H1) ||
           (s == ST_SET_M10) || (s == ST_SET_M1);
  endfunction

  function automatic logic [3:0] sel_of(state_t s);
    case (s)
      ST_SET_H10: return 4'b1000;
      ST_SET_H1:  return 4'b0100;
      ST_SET_M10: return 4'b0010;
      ST_SET_M1:  return 4'b0001;
      default:    return 4'b0000;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    case (state_q)
      ST_RUN:     if (mode_evt) state_d = ST_SET_H10;
      ST_SET_H10: if (mode_evt) state_d = ST_SET_H1;
      ST_SET_H1:  if (mode_evt) state_d = ST_SET_M10;
      ST_SET_M10: if (mode_evt) state_d = ST_SET_M1;
      ST_SET_M1: begin
        if (mode_evt) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (load_cnt_q == LOAD_W'(LOAD_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    h10_d = h10_q;
    h1_d  = h1_q;
    m10_d = m10_q;
    m1_d  = m1_q;
    // A simultaneous mode press takes priority and swallows the increment.
    if (inc_evt && !mode_evt) begin
      case (state_q)
        ST_SET_H10: begin
          h10_d = (h10_q == 4'd2) ? 4'd0 : h10_q + 4'd1;
          // Keep the hour legal (max 23) when tens becomes 2.
          if (h10_d == 4'd2 && h1_q > 4'd3) h1_d = 4'd3;
        end
        ST_SET_H1: begin
          if (h10_q == 4'd2) h1_d = (h1_q >= 4'd3) ? 4'd0 : h1_q + 4'd1;
          else               h1_d = (h1_q >= 4'd9) ? 4'd0 : h1_q + 4'd1;
        end
        ST_SET_M10: m10_d = (m10_q >= 4'd5) ? 4'd0 : m10_q + 4'd1;
        ST_SET_M1:  m1_d  = (m1_q  >= 4'd9) ? 4'd0 : m1_q  + 4'd1;
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Blink generator: restarts high on every entry into an edit state.
  // ------------------------------------------------------------------
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (!is_set(state_d)) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (state_d != state_q) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  logic       load_q, setting_q;
  logic [3:0] sel_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_RUN;
      load_cnt_q  <= '0;
      h10_q       <= 4'd0;
      h1_q        <= 4'd0;
      m10_q       <= 4'd0;
      m1_q        <= 4'd0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      load_q      <= 1'b0;
      setting_q   <= 1'b0;
      sel_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      h10_q       <= h10_d;
      h1_q        <= h1_d;
      m10_q       <= m10_d;
      m1_q        <= m1_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      // Decodes are registered from the next state so they line up with state_q.
      load_q      <= (state_d == ST_LOAD);
      setting_q   <= is_set(state_d);
      sel_q       <= sel_of(state_d);
    end
  end

  assign ival_h10_o = h10_q;
  assign ival_h1_o  = h1_q;
  assign ival_m10_o = m10_q;
  assign ival_m1_o  = m1_q;
  assign load_o     = load_q;
  assign setting_o  = setting_q;
  assign sel_o      = sel_q;
  assign blink_o    = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: self-checking bench for watch_set_ctrl.
//   Drives clean button presses and short glitches; a press-level reference
//   model predicts edit state and digits, plus hand-timed latency/load/blink/reset checks.
module tb_watch_set_ctrl;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       btn_mode_i, btn_inc_i;
  logic [3:0] ival_h10_o, ival_h1_o, ival_m10_o, ival_m1_o;
  logic       load_o, setting_o, blink_o;
  logic [3:0] sel_o;

  watch_set_ctrl #(.DEB_CYCLES(4), .LOAD_CYCLES(2), .BLINK_DIV(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .btn_mode_i(btn_mode_i), .btn_inc_i(btn_inc_i),
    .ival_h10_o(ival_h10_o), .ival_h1_o(ival_h1_o),
    .ival_m10_o(ival_m10_o), .ival_m1_o(ival_m1_o),
    .load_o(load_o), .setting_o(setting_o), .sel_o(sel_o), .blink_o(blink_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: st 0 = running, 1..4 = editing H10,H1,M10,M1.
  int st;
  int dg [4];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    st = 0;
    for (int k = 0; k < 4; k++) dg[k] = 0;
  endtask

  task automatic model_press(input bit m, input bit i);
    if (m) begin
      st = (st == 4) ? 0 : st + 1;   // leaving M1 passes through the load and back to run
    end else if (i && st >= 1) begin
      case (st)
        1: begin
          dg[0] = (dg[0] + 1) % 3;
          if (dg[0] == 2 && dg[1] > 3) dg[1] = 3;
        end
        2: dg[1] = (dg[1] + 1) % ((dg[0] == 2) ? 4 : 10);
        3: dg[2] = (dg[2] + 1) % 6;
        default: dg[3] = (dg[3] + 1) % 10;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " sel"},     int'(sel_o), (st >= 1) ? (1 << (4 - st)) : 0);
    chk({tag, " setting"}, int'(setting_o), (st >= 1) ? 1 : 0);
    chk({tag, " load"},    int'(load_o), 0);
    chk({tag, " h10"},     int'(ival_h10_o), dg[0]);
    chk({tag, " h1"},      int'(ival_h1_o),  dg[1]);
    chk({tag, " m10"},     int'(ival_m10_o), dg[2]);
    chk({tag, " m1"},      int'(ival_m1_o),  dg[3]);
  endtask

  // Hold buttons long enough to debounce, release and let the release settle.
  task automatic press(input bit m, input bit i, input int hold);
    btn_mode_i = m;
    btn_inc_i  = i;
    tick(hold);
    btn_mode_i = 1'b0;
    btn_inc_i  = 1'b0;
    tick(8);
    model_press(m, i);
  endtask

  task automatic glitch(input bit m, input int len);
    if (m) btn_mode_i = 1'b1; else btn_inc_i = 1'b1;
    tick(len);
    btn_mode_i = 1'b0;
    btn_inc_i  = 1'b0;
    tick(8);
  endtask

  typedef struct {
    bit m;
    bit i;
    int sel;
    int h10, h1, m10, m1;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Entry sequence after the first mode press (SET_H10), digits from 0000.
    vecs[0]  = '{0, 1, 8, 1, 0, 0, 0};
    vecs[1]  = '{0, 1, 8, 2, 0, 0, 0};
    vecs[2]  = '{1, 0, 4, 2, 0, 0, 0};
    vecs[3]  = '{0, 1, 4, 2, 1, 0, 0};
    vecs[4]  = '{0, 1, 4, 2, 2, 0, 0};
    vecs[5]  = '{0, 1, 4, 2, 3, 0, 0};
    vecs[6]  = '{0, 1, 4, 2, 0, 0, 0};
    vecs[7]  = '{0, 1, 4, 2, 1, 0, 0};
    vecs[8]  = '{1, 0, 2, 2, 1, 0, 0};
    vecs[9]  = '{0, 1, 2, 2, 1, 1, 0};
    vecs[10] = '{0, 1, 2, 2, 1, 2, 0};
    vecs[11] = '{0, 1, 2, 2, 1, 3, 0};
    vecs[12] = '{1, 0, 1, 2, 1, 3, 0};
    for (int k = 13; k < 20; k++) vecs[k] = '{0, 1, 1, 2, 1, 3, k - 12};

    // Reset state
    rstn_i = 1'b0; btn_mode_i = 1'b0; btn_inc_i = 1'b0;
    model_reset();
    #25 rstn_i = 1'b1;
    tick(20);
    check_all("reset");
    chk("reset blink", int'(blink_o), 0);

    // Short increment glitch and a full increment press while running: no effect.
    glitch(1'b0, 3);
    check_all("inc glitch run");
    press(1'b0, 1'b1, 10);
    check_all("inc in run");
    glitch(1'b1, 3);
    check_all("mode glitch run");

    // First mode press: exact latency, then blink pattern from entry.
    btn_mode_i = 1'b1;
    tick(6);
    chk("latency before sel", int'(sel_o), 0);
    tick(1);
    chk("latency at sel", int'(sel_o), 8);
    chk("entry blink", int'(blink_o), 1);
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) btn_mode_i = 1'b0;
      tick(1);
      chk($sformatf("blink k=%0d", k), int'(blink_o), ((k / 16) % 2 == 0) ? 1 : 0);
    end
    tick(8);
    model_press(1'b1, 1'b0);
    check_all("set h10");

    // Table-driven edit sequence.
    for (int k = 0; k < 20; k++) begin
      press(vecs[k].m, vecs[k].i, 10);
      chk($sformatf("vec%0d sel", k), int'(sel_o), vecs[k].sel);
      chk($sformatf("vec%0d h10", k), int'(ival_h10_o), vecs[k].h10);
      chk($sformatf("vec%0d h1", k),  int'(ival_h1_o),  vecs[k].h1);
      chk($sformatf("vec%0d m10", k), int'(ival_m10_o), vecs[k].m10);
      chk($sformatf("vec%0d m1", k),  int'(ival_m1_o),  vecs[k].m1);
    end

    // Final mode press: load strobe exactly two cycles.
    btn_mode_i = 1'b1;
    tick(6);
    chk("pre-load load", int'(load_o), 0);
    chk("pre-load sel", int'(sel_o), 1);
    tick(1);
    chk("load c1", int'(load_o), 1);
    chk("load c1 setting", int'(setting_o), 0);
    chk("load c1 sel", int'(sel_o), 0);
    chk("load c1 blink", int'(blink_o), 0);
    chk("load c1 m1", int'(ival_m1_o), 7);
    tick(1);
    chk("load c2", int'(load_o), 1);
    tick(1);
    chk("load c3", int'(load_o), 0);
    btn_mode_i = 1'b0;
    tick(8);
    model_press(1'b1, 1'b0);
    check_all("after load");
    chk("loaded h10", int'(ival_h10_o), 2);
    chk("loaded m1", int'(ival_m1_o), 7);

    // H1 clamp when H10 becomes 2.
    press(1'b1, 1'b0, 10);                          // SET_H10
    press(1'b0, 1'b1, 10);                          // H10 2 -> 0
    press(1'b0, 1'b1, 10);                          // H10 -> 1
    press(1'b1, 1'b0, 10);                          // SET_H1
    while (dg[1] != 9) press(1'b0, 1'b1, 10);
    check_all("h1 at 9");
    for (int k = 0; k < 4; k++) press(1'b1, 1'b0, 10);  // around to SET_H10
    check_all("back at h10");
    press(1'b0, 1'b1, 10);
    check_all("clamp");
    chk("clamp h1 const", int'(ival_h1_o), 3);

    // Simultaneous mode and increment in SET_M10: mode wins.
    press(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 10);
    check_all("at m10");
    press(1'b1, 1'b1, 10);
    check_all("mode+inc");
    chk("mode+inc sel", int'(sel_o), 1);

    // Randomised presses and glitches against the model.
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3)      press(1'b1, 1'b0, $urandom_range(8, 14));
      else if (r <= 7) press(1'b0, 1'b1, $urandom_range(8, 14));
      else if (r == 8) glitch($urandom_range(0, 1) == 1, $urandom_range(1, 3));
      else             press(1'b1, 1'b1, $urandom_range(8, 14));
      check_all($sformatf("rnd%0d", n));
    end

    // Asynchronous reset during the first load cycle.
    while (st != 4) press(1'b1, 1'b0, 10);
    btn_mode_i = 1'b1;
    tick(7);
    chk("rst-load before", int'(load_o), 1);
    #2 rstn_i = 1'b0;
    #1;
    chk("rst-load async drop", int'(load_o), 0);
    btn_mode_i = 1'b0;
    #10 rstn_i = 1'b1;
    model_reset();
    tick(12);
    check_all("after rst");
    chk("after rst blink", int'(blink_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
